// File: rtl/branch_predictor.sv
// Branch target buffer with a per-entry saturating-counter direction predictor.
// Fetch looks up a PC and gets a registered prediction one cycle later; execute
// trains the table with resolved outcomes. Optional statistics counters are
// built when the macro BP_STATS_EN is defined; otherwise both ports read 0.
module branch_predictor #(
  parameter int XLEN    = 32,
  parameter int ENTRIES = 64,
  parameter int CNT_W   = 2
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            i_fu_valid,
  input  logic [XLEN-1:0] i_fu_pc,
  output logic            o_fu_hit,
  output logic            o_fu_taken,
  output logic [XLEN-1:0] o_fu_target,
  input  logic            i_exec_upd_en,
  input  logic [XLEN-1:0] i_exec_pc,
  input  logic            i_exec_taken,
  input  logic            i_exec_is_jump,
  input  logic [XLEN-1:0] i_exec_target,
  input  logic            i_exec_mispredict,
  input  logic            i_inval_all,
  output logic [31:0]     o_stat_lookups,
  output logic [31:0]     o_stat_mispredicts
);

  localparam int IDX_W = $clog2(ENTRIES);
  localparam int TAG_W = XLEN - 2 - IDX_W;
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;
  localparam logic [CNT_W-1:0] CNT_WEAK = CNT_W'(1 << (CNT_W - 1));

  // Valid bits live in flops so the whole table can be flushed in one edge;
  // the payload fields are plain arrays with no reset (gated by valid).
  logic [ENTRIES-1:0] valid_q, valid_d;
  logic [TAG_W-1:0]   tag_mem [ENTRIES];
  logic [XLEN-1:0]    tgt_mem [ENTRIES];
  logic [CNT_W-1:0]   cnt_mem [ENTRIES];
  logic               jmp_mem [ENTRIES];

  logic            hit_q, hit_d;
  logic            taken_q, taken_d;
  logic [XLEN-1:0] target_q, target_d;

  logic [IDX_W-1:0] fu_idx, ex_idx;
  logic [TAG_W-1:0] fu_tag, ex_tag;
  logic             fu_hit, fu_taken;
  logic             ex_hit, upd_ok, wr_entry, wr_cnt, alloc;
  logic [CNT_W-1:0] cnt_old, cnt_new;

  assign fu_idx = i_fu_pc[IDX_W+1:2];
  assign fu_tag = i_fu_pc[XLEN-1:IDX_W+2];
  assign ex_idx = i_exec_pc[IDX_W+1:2];
  assign ex_tag = i_exec_pc[XLEN-1:IDX_W+2];

  // Lookup: read current (pre-update) contents; hold outputs while fetch stalls.
  always_comb begin
    fu_hit   = valid_q[fu_idx] && (tag_mem[fu_idx] == fu_tag) && (i_fu_pc[1:0] == 2'b00);
    fu_taken = fu_hit && (jmp_mem[fu_idx] || cnt_mem[fu_idx][CNT_W-1]);
    hit_d    = hit_q;
    taken_d  = taken_q;
    target_d = target_q;
    if (i_fu_valid) begin
      hit_d    = fu_hit;
      taken_d  = fu_taken;
      target_d = fu_taken ? tgt_mem[fu_idx] : '0;
    end
  end

  // Training decode: misaligned updates and updates racing a flush are dropped.
  always_comb begin
    cnt_old  = cnt_mem[ex_idx];
    ex_hit   = valid_q[ex_idx] && (tag_mem[ex_idx] == ex_tag);
    upd_ok   = i_exec_upd_en && (i_exec_pc[1:0] == 2'b00) && !i_inval_all;
    wr_entry = upd_ok && i_exec_taken;
    wr_cnt   = upd_ok && (ex_hit || i_exec_taken);
    alloc    = upd_ok && !ex_hit && i_exec_taken;
    cnt_new  = CNT_WEAK;
    if (ex_hit) begin
      if (i_exec_taken) begin
        cnt_new = (cnt_old == CNT_MAX) ? cnt_old : cnt_old + CNT_W'(1);
      end else begin
        cnt_new = (cnt_old == '0) ? cnt_old : cnt_old - CNT_W'(1);
      end
    end
  end

  // Per-entry valid next state: flush wins, then allocation sets the bit.
  for (genvar gi = 0; gi < ENTRIES; gi++) begin : g_valid
    assign valid_d[gi] = i_inval_all ? 1'b0 :
                         (alloc && (ex_idx == IDX_W'(gi))) ? 1'b1 : valid_q[gi];
  end

  // Valid bits and registered lookup result.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q  <= '0;
      hit_q    <= 1'b0;
      taken_q  <= 1'b0;
      target_q <= '0;
    end else begin
      valid_q  <= valid_d;
      hit_q    <= hit_d;
      taken_q  <= taken_d;
      target_q <= target_d;
    end
  end

  // Table payload writes; a reset edge discards the same-cycle update.
  always_ff @(posedge clk) begin
    if (!rst && wr_entry) begin
      tag_mem[ex_idx] <= ex_tag;
      tgt_mem[ex_idx] <= i_exec_target;
      jmp_mem[ex_idx] <= i_exec_is_jump;
    end
    if (!rst && wr_cnt) begin
      cnt_mem[ex_idx] <= cnt_new;
    end
  end

  assign o_fu_hit    = hit_q;
  assign o_fu_taken  = taken_q;
  assign o_fu_target = target_q;

`ifdef BP_STATS_EN
  logic [31:0] stat_lookups_q, stat_lookups_d;
  logic [31:0] stat_mispred_q, stat_mispred_d;

  // Saturating event counters; untouched by the table flush.
  always_comb begin
    stat_lookups_d = stat_lookups_q;
    stat_mispred_d = stat_mispred_q;
    if (i_fu_valid && (stat_lookups_q != 32'hFFFF_FFFF)) begin
      stat_lookups_d = stat_lookups_q + 32'd1;
    end
    if (i_exec_upd_en && i_exec_mispredict && (stat_mispred_q != 32'hFFFF_FFFF)) begin
      stat_mispred_d = stat_mispred_q + 32'd1;
    end
  end

  // Statistics registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      stat_lookups_q <= '0;
      stat_mispred_q <= '0;
    end else begin
      stat_lookups_q <= stat_lookups_d;
      stat_mispred_q <= stat_mispred_d;
    end
  end

  assign o_stat_lookups     = stat_lookups_q;
  assign o_stat_mispredicts = stat_mispred_q;
`else
  logic unused_stat_in;
  assign unused_stat_in     = i_exec_mispredict;
  assign o_stat_lookups     = '0;
  assign o_stat_mispredicts = '0;
`endif

endmodule

// File: tb/tb_branch_predictor.sv
// Directed testbench for branch_predictor (default parameters: XLEN=32, ENTRIES=64, CNT_W=2).
module tb_branch_predictor;
  logic        clk = 1'b0;
  logic        rst;
  logic        i_fu_valid;
  logic [31:0] i_fu_pc;
  logic        o_fu_hit;
  logic        o_fu_taken;
  logic [31:0] o_fu_target;
  logic        i_exec_upd_en;
  logic [31:0] i_exec_pc;
  logic        i_exec_taken;
  logic        i_exec_is_jump;
  logic [31:0] i_exec_target;
  logic        i_exec_mispredict;
  logic        i_inval_all;
  logic [31:0] o_stat_lookups;
  logic [31:0] o_stat_mispredicts;

  int pass_cnt = 0;
  int total_cnt = 0;

  branch_predictor #(.XLEN(32), .ENTRIES(64), .CNT_W(2)) dut (
    .clk(clk), .rst(rst),
    .i_fu_valid(i_fu_valid), .i_fu_pc(i_fu_pc),
    .o_fu_hit(o_fu_hit), .o_fu_taken(o_fu_taken), .o_fu_target(o_fu_target),
    .i_exec_upd_en(i_exec_upd_en), .i_exec_pc(i_exec_pc), .i_exec_taken(i_exec_taken),
    .i_exec_is_jump(i_exec_is_jump), .i_exec_target(i_exec_target),
    .i_exec_mispredict(i_exec_mispredict), .i_inval_all(i_inval_all),
    .o_stat_lookups(o_stat_lookups), .o_stat_mispredicts(o_stat_mispredicts)
  );

  always #5 clk = ~clk;

  // Stimulus helpers: inputs change 1 time unit after the rising edge, outputs are sampled there too.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic lookup(input logic [31:0] pc);
    i_fu_valid = 1'b1;
    i_fu_pc    = pc;
    tick();
    i_fu_valid = 1'b0;
  endtask

  task automatic update(input logic [31:0] pc, input logic taken, input logic jump,
                        input logic [31:0] tgt);
    i_exec_upd_en  = 1'b1;
    i_exec_pc      = pc;
    i_exec_taken   = taken;
    i_exec_is_jump = jump;
    i_exec_target  = tgt;
    tick();
    i_exec_upd_en  = 1'b0;
  endtask

  task automatic check_pred(input string name, input logic hit, input logic taken,
                            input logic [31:0] tgt);
    total_cnt++;
    if ({o_fu_hit, o_fu_taken, o_fu_target} !== {hit, taken, tgt}) begin
      $display("FAIL %s: got hit=%0b taken=%0b target=%h, expected hit=%0b taken=%0b target=%h",
               name, o_fu_hit, o_fu_taken, o_fu_target, hit, taken, tgt);
    end else begin
      pass_cnt++;
      $display("ok   %s: hit=%0b taken=%0b target=%h", name, o_fu_hit, o_fu_taken, o_fu_target);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    total_cnt++;
    if ({o_fu_hit, o_fu_taken, o_fu_target, o_stat_lookups, o_stat_mispredicts} !== 98'd0) begin
      $display("FAIL reset_outputs: got hit=%0b taken=%0b target=%h lk=%0d mp=%0d, expected all 0",
               o_fu_hit, o_fu_taken, o_fu_target, o_stat_lookups, o_stat_mispredicts);
    end else begin
      pass_cnt++;
      $display("ok   reset_outputs");
    end
    rst = 1'b0;
    lookup(32'h100);
    check_pred("empty_lookup", 1'b0, 1'b0, 32'h0);
  endtask

  task automatic test_counter();
    update(32'h100, 1'b1, 1'b0, 32'h200);
    lookup(32'h100);
    check_pred("alloc_weak_taken", 1'b1, 1'b1, 32'h200);
    update(32'h100, 1'b0, 1'b0, 32'h0);
    lookup(32'h100);
    check_pred("cnt_2_to_1", 1'b1, 1'b0, 32'h0);
    update(32'h100, 1'b0, 1'b0, 32'h0);
    lookup(32'h100);
    check_pred("cnt_1_to_0", 1'b1, 1'b0, 32'h0);
    update(32'h100, 1'b0, 1'b0, 32'h0);
    update(32'h100, 1'b1, 1'b0, 32'h200);
    lookup(32'h100);
    check_pred("cnt_sat_low", 1'b1, 1'b0, 32'h0);
    update(32'h100, 1'b1, 1'b0, 32'h240);
    lookup(32'h100);
    check_pred("target_overwrite", 1'b1, 1'b1, 32'h240);
    update(32'h100, 1'b1, 1'b0, 32'h240);
    update(32'h100, 1'b1, 1'b0, 32'h240);
    update(32'h100, 1'b0, 1'b0, 32'h0);
    lookup(32'h100);
    check_pred("cnt_sat_high", 1'b1, 1'b1, 32'h240);
  endtask

  task automatic test_hold();
    lookup(32'h100);
    i_fu_valid = 1'b0;
    i_fu_pc    = 32'h104;
    tick();
    check_pred("stall_hold", 1'b1, 1'b1, 32'h240);
  endtask

  task automatic test_misaligned();
    lookup(32'h102);
    check_pred("misaligned_lookup", 1'b0, 1'b0, 32'h0);
    update(32'h102, 1'b0, 1'b0, 32'h0);
    lookup(32'h100);
    check_pred("misaligned_upd_nt", 1'b1, 1'b1, 32'h240);
    update(32'h106, 1'b1, 1'b0, 32'h999);
    lookup(32'h104);
    check_pred("misaligned_upd_t", 1'b0, 1'b0, 32'h0);
  endtask

  task automatic test_alias();
    lookup(32'h200);
    check_pred("alias_miss", 1'b0, 1'b0, 32'h0);
    update(32'h200, 1'b1, 1'b0, 32'h500);
    lookup(32'h100);
    check_pred("alias_evicts", 1'b0, 1'b0, 32'h0);
    lookup(32'h200);
    check_pred("alias_hit", 1'b1, 1'b1, 32'h500);
  endtask

  task automatic test_same_cycle();
    i_fu_valid = 1'b1;
    i_fu_pc    = 32'h300;
    update(32'h300, 1'b1, 1'b0, 32'h340);
    i_fu_valid = 1'b0;
    check_pred("rbw_alloc_miss", 1'b0, 1'b0, 32'h0);
    lookup(32'h300);
    check_pred("rbw_alloc_after", 1'b1, 1'b1, 32'h340);
    i_fu_valid = 1'b1;
    i_fu_pc    = 32'h300;
    update(32'h300, 1'b0, 1'b0, 32'h0);
    i_fu_valid = 1'b0;
    check_pred("rbw_old_cnt", 1'b1, 1'b1, 32'h340);
    lookup(32'h300);
    check_pred("rbw_new_cnt", 1'b1, 1'b0, 32'h0);
  endtask

  task automatic test_jump_inval();
    update(32'h400, 1'b1, 1'b1, 32'h800);
    for (int k = 0; k < 3; k++) update(32'h400, 1'b0, 1'b0, 32'h0);
    lookup(32'h400);
    check_pred("jump_always_taken", 1'b1, 1'b1, 32'h800);
    i_inval_all = 1'b1;
    i_fu_valid  = 1'b1;
    i_fu_pc     = 32'h400;
    update(32'h604, 1'b1, 1'b0, 32'h111);
    i_fu_valid  = 1'b0;
    i_inval_all = 1'b0;
    check_pred("inval_same_lookup", 1'b1, 1'b1, 32'h800);
    lookup(32'h400);
    check_pred("inval_cleared", 1'b0, 1'b0, 32'h0);
    lookup(32'h604);
    check_pred("inval_beats_update", 1'b0, 1'b0, 32'h0);
  endtask

  task automatic test_reset_mid();
    update(32'h104, 1'b1, 1'b0, 32'h900);
    lookup(32'h104);
    check_pred("pre_reset_hit", 1'b1, 1'b1, 32'h900);
    rst        = 1'b1;
    i_fu_valid = 1'b1;
    i_fu_pc    = 32'h104;
    update(32'h108, 1'b1, 1'b0, 32'h910);
    i_fu_valid = 1'b0;
    rst        = 1'b0;
    check_pred("mid_reset_outputs", 1'b0, 1'b0, 32'h0);
    lookup(32'h104);
    check_pred("mid_reset_cleared", 1'b0, 1'b0, 32'h0);
    lookup(32'h108);
    check_pred("mid_reset_upd_drop", 1'b0, 1'b0, 32'h0);
  endtask

  task automatic test_stats();
    logic [31:0] exp_lk;
    logic [31:0] exp_mp;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    for (int k = 0; k < 10; k++) begin
      lookup(32'h1000 + 32'(k * 4));
      if (k == 3 || k == 7) tick();
    end
    i_exec_mispredict = 1'b1;
    for (int k = 0; k < 3; k++) update(32'h2000, 1'b1, 1'b0, 32'h3000);
    tick();
    i_exec_mispredict = 1'b0;
    update(32'h2000, 1'b1, 1'b0, 32'h3000);
    i_inval_all = 1'b1;
    tick();
    i_inval_all = 1'b0;
`ifdef BP_STATS_EN
    exp_lk = 32'd10;
    exp_mp = 32'd3;
`else
    exp_lk = 32'd0;
    exp_mp = 32'd0;
`endif
    total_cnt++;
    if (o_stat_lookups !== exp_lk) begin
      $display("FAIL stat_lookups: got %0d, expected %0d", o_stat_lookups, exp_lk);
    end else begin
      pass_cnt++;
      $display("ok   stat_lookups: %0d", o_stat_lookups);
    end
    total_cnt++;
    if (o_stat_mispredicts !== exp_mp) begin
      $display("FAIL stat_mispredicts: got %0d, expected %0d", o_stat_mispredicts, exp_mp);
    end else begin
      pass_cnt++;
      $display("ok   stat_mispredicts: %0d", o_stat_mispredicts);
    end
  endtask

  initial begin
    rst               = 1'b1;
    i_fu_valid        = 1'b0;
    i_fu_pc           = '0;
    i_exec_upd_en     = 1'b0;
    i_exec_pc         = '0;
    i_exec_taken      = 1'b0;
    i_exec_is_jump    = 1'b0;
    i_exec_target     = '0;
    i_exec_mispredict = 1'b0;
    i_inval_all       = 1'b0;
    test_reset();
    test_counter();
    test_hold();
    test_misaligned();
    test_alias();
    test_same_cycle();
    test_jump_inval();
    test_reset_mid();
    test_stats();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule
